// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Purpose  : Shared core constants and the fetch-stage state encoding.
// Contents : XLEN, INST_W, PC_STEP, fetch_state_e {FETCH_FLUSH, FETCH_RUN}
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int XLEN    = 32;
  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [0:0] {
    FETCH_FLUSH = 1'b0,
    FETCH_RUN   = 1'b1
  } fetch_state_e;

endpackage : core_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH-entry synchronous FIFO holding {instruction, pc} pairs.
//            Supports simultaneous push and pop and a single-cycle flush.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            flush           - drop all entries (wins over push/pop)
//            push, push_data - write one entry
//            pop             - retire the head entry
//            head_data       - registered head entry
//            count           - number of valid entries (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  assign head_data = mem[rptr];

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Steps the external PC block, reads
//            instruction memory, buffers {inst, pc} in a FIFO for decode and
//            handles redirects from execute.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            pc                       - current PC from the PC block
//            pcread / pcenable        - advance PC by 4 / load next_pc
//            next_pc                  - redirect target towards PC block
//            imem_en / imem_addr      - instruction memory read request
//            imem_rdata               - read data, one cycle after imem_en
//            redirect / redirect_pc   - taken branch/jump from execute
//            inst_valid / inst / inst_pc / inst_ready - decode handshake
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import core_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int IMEM_AW = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     pc,
  output logic                pcread,
  output logic                pcenable,
  output logic [XLEN-1:0]     next_pc,
  output logic                imem_en,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [INST_W-1:0]   imem_rdata,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                inst_valid,
  output logic [INST_W-1:0]   inst,
  output logic [XLEN-1:0]     inst_pc,
  input  logic                inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INST_W + XLEN;

  fetch_state_e state;
  fetch_state_e state_nxt;

  logic               inflight;
  logic [XLEN-1:0]    tag;
  logic               issue;
  logic               credit_ok;
  logic               fifo_push;
  logic               fifo_pop;
  logic [EW-1:0]      head;
  logic [CW-1:0]      count;

  // Reserve a FIFO slot for every outstanding read so a return can never
  // find the FIFO full. count + 1 always fits in CW bits since DEPTH >= 2.
  assign credit_ok = (count + CW'(inflight)) < CW'(DEPTH);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_FLUSH;
    else     state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // Next state and PC/memory control
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    pcread    = 1'b0;
    pcenable  = 1'b0;
    next_pc   = '0;
    imem_en   = 1'b0;
    if (rst) begin
      state_nxt = FETCH_FLUSH;
    end else if (redirect) begin
      // Redirect is honoured in any state; a later one simply overrides.
      pcenable  = 1'b1;
      next_pc   = redirect_pc;
      state_nxt = FETCH_FLUSH;
    end else begin
      case (state)
        FETCH_FLUSH: state_nxt = FETCH_RUN;
        FETCH_RUN: begin
          if (credit_ok) begin
            issue   = 1'b1;
            pcread  = 1'b1;
            imem_en = 1'b1;
          end
        end
        default: state_nxt = FETCH_FLUSH;
      endcase
    end
  end

  assign imem_addr = pc[IMEM_AW+1:2];

  // --------------------------------------------------------------------------
  // Outstanding read tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      tag      <= '0;
    end else begin
      inflight <= issue;
      if (issue) tag <= pc;
    end
  end

  // A read outstanding during a redirect returns in that same cycle; the
  // push is suppressed and the FIFO flush wins, so the stale word is lost.
  // No read can be issued in a redirect cycle, so nothing survives it.
  assign fifo_push = inflight && !redirect && !rst;
  assign fifo_pop  = inst_valid && inst_ready;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data ({imem_rdata, tag}),
    .pop       (fifo_pop),
    .head_data (head),
    .count     (count)
  );

  // Decode-side outputs are straight from FIFO registers, forced low in reset.
  assign inst_valid = !rst && (count != '0);
  assign inst       = rst ? '0 : head[EW-1:XLEN];
  assign inst_pc    = rst ? '0 : head[XLEN-1:0];

endmodule : fetch_unit
`default_nettype wire
